free_list_mgr: RTL and testbench
================================

// Module: free_list_mgr
// PURPOSE
//  Stateful one-hot free list: tracks SIZE allocatable entries (ROB/phys-reg/LSQ slots).
//  Allocation hands out the lowest-index free entry; release returns any set of entries.
//  Sits between the rename/dispatch stage (allocator) and commit/squash logic (releaser).
// PARAMETERS
//  SIZE   8   number of managed entries (>=2)
//  IDX_W  $clog2(SIZE)   width of encoded index (derived, not overridden)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  alloc_req    in   1       allocator requests one entry this cycle
//  alloc_ready  out  1       at least one entry free (registered state, not bypassed)
//  alloc_onehot out  SIZE    one-hot of lowest free entry; all-zero when !alloc_ready
//  alloc_idx    out  IDX_W   binary encoding of alloc_onehot; 0 when !alloc_ready
//  rel_valid    in   1       release strobe
//  rel_onehot   in   SIZE    entries to return (any number of bits set)
//  flush        in   1       return every entry to free
//  free_cnt     out  IDX_W+1 registered count of free entries
//  full         out  1       free_cnt==SIZE (nothing allocated)
//  empty        out  1       free_cnt==0
//  err          out  1       sticky: release of an already-free entry (see CONFIGURATION)
// BEHAVIOUR
//  - State: free_mask[SIZE-1:0] register, bit=1 means free; free_cnt register.
//  - Reset: free_mask=all 1s, free_cnt=SIZE, full=1, empty=0, alloc_ready=1, err=0.
//  - alloc_onehot/alloc_idx/alloc_ready are combinational from free_mask only (zero latency).
//  - alloc_fire = alloc_req & alloc_ready; selected bit cleared at next posedge.
//  - alloc_req while !alloc_ready: no state change, no error; requester holds/retries.
//  - rel_fire = rel_valid; bits in rel_onehot set in free_mask at next posedge.
//  - Released entries are NOT bypassed: visible to allocation one cycle after release.
//  - Same-cycle alloc+release: both applied; next_mask = (mask & ~alloc_onehot) | rel_onehot.
//  - free_cnt_next = free_cnt - alloc_fire + popcount(rel_onehot & ~free_mask) when rel_valid;
//    count derived from bits actually transitioning, so it always equals popcount(free_mask).
//  - flush: highest priority; next_mask=all 1s, free_cnt=SIZE; alloc/release that cycle ignored;
//    alloc_fire that cycle still reports alloc_onehot but the entry is considered returned.
//  - rst dominates flush; reset mid-operation discards all outstanding allocations.
//  - Priority: rst > flush > (alloc, release merged). err unaffected by flush, cleared by rst.
// CONFIGURATION
//  FREE_LIST_CHECK_EN defined: err set (sticky) when rel_valid & |(rel_onehot & free_mask),
//    or rel_onehot has bits >= SIZE-valid range violated; simulation $error also emitted.
//    Offending bits still OR in (idempotent), count unaffected by them.
//  Undefined: err tied 0; no detection logic synthesised; double release silently idempotent.
// STRUCTURE
//  - Package free_list_pkg: function popcount(SIZE), function onehot2idx, localparam helpers
//    for IDX_W/CNT_W; shared with other free-list consumers.
//  - Sub-module: selFl (existing lowest-set-bit one-hot selector) instantiated on free_mask
//    to produce alloc_onehot; encoding via free_list_pkg::onehot2idx.
// TESTING (SIZE=8)
//  - Reset: rst=1 one cycle -> free_cnt=8, full=1, alloc_onehot=8'h01, alloc_idx=0, err=0.
//  - 8 back-to-back alloc_req -> idx 0..7 in order, free_cnt 8..1 then 0, empty=1,
//    alloc_ready=0; 9th req: no change, alloc_onehot=0.
//  - From empty, release 8'b0010_0100 -> next cycle free_cnt=2, alloc_idx=2; alloc then idx=5.
//  - Same cycle alloc (idx 0) + release 8'h80 with mask 8'h01 -> mask 8'h80, free_cnt=1.
//  - Flush with mask 8'h00 plus alloc_req -> next cycle mask 8'hFF, free_cnt=8, full=1.
//  - CHECK_EN: release 8'h01 while entry 0 free -> err=1 and stays 1, free_cnt unchanged;
//    without macro err stays 0. Plus random alloc/release run: free_cnt==popcount(mask) always.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared free-list helpers: index/count widths, popcount and one-hot encode.
// Supports up to MAX_SIZE managed entries.
package free_list_pkg;

    localparam int MAX_SIZE  = 64;
    localparam int MAX_IDX_W = 6;

    function automatic int idx_w(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

    function automatic int cnt_w(input int size);
        return idx_w(size) + 1;
    endfunction

    function automatic logic [MAX_IDX_W:0] popcount(input logic [MAX_SIZE-1:0] v);
        logic [MAX_IDX_W:0] c;
        c = '0;
        for (int i = 0; i < MAX_SIZE; i++)
            c = c + {{MAX_IDX_W{1'b0}}, v[i]};
        return c;
    endfunction

    // OR-reduction encoder: exact for one-hot input, 0 for all-zero input
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_SIZE-1:0] oh);
        logic [MAX_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_SIZE; i++)
            if (oh[i]) r = r | MAX_IDX_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/selFl.sv
// Lowest-set-bit one-hot selector; gnt is all-zero when req is all-zero.
module selFl #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    // two's complement isolates the lowest set bit
    assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/free_list_mgr.sv
// One-hot free list with lowest-index allocation and multi-entry release.
// Optional FREE_LIST_CHECK_EN adds sticky double-release detection on err.
module free_list_mgr
    import free_list_pkg::*;
#(
    parameter  int SIZE  = 8,
    localparam int IDX_W = idx_w(SIZE),
    localparam int CNT_W = cnt_w(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_ready,
    output logic [SIZE-1:0]  alloc_onehot,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             rel_valid,
    input  logic [SIZE-1:0]  rel_onehot,
    input  logic             flush,
    output logic [CNT_W-1:0] free_cnt,
    output logic             full,
    output logic             empty,
    output logic             err
);

    logic [SIZE-1:0]  free_mask, next_mask, alloc_sel;
    logic [SIZE-1:0]  alloc_clr, rel_bits, rm_bits, add_bits;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             alloc_fire;

    selFl #(.W(SIZE)) u_sel (
        .req (free_mask),
        .gnt (alloc_sel)
    );

    assign alloc_ready  = |free_mask;
    assign alloc_onehot = alloc_sel;
    assign alloc_idx    = IDX_W'(onehot2idx(MAX_SIZE'(alloc_sel)));
    assign alloc_fire   = alloc_req & alloc_ready;

    assign free_cnt = cnt_q;
    assign full     = (cnt_q == CNT_W'(SIZE));
    assign empty    = (cnt_q == '0);

    always_comb begin
        alloc_clr = alloc_fire ? alloc_sel : '0;
        rel_bits  = rel_valid ? rel_onehot : '0;
        next_mask = (free_mask & ~alloc_clr) | rel_bits;
        if (flush)
            next_mask = '1;
        // count follows actual bit transitions so it never drifts from the mask
        rm_bits  = free_mask & ~next_mask;
        add_bits = ~free_mask & next_mask;
        cnt_next = cnt_q - CNT_W'(popcount(MAX_SIZE'(rm_bits)))
                         + CNT_W'(popcount(MAX_SIZE'(add_bits)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_mask <= '1;
            cnt_q     <= CNT_W'(SIZE);
        end else begin
            free_mask <= next_mask;
            cnt_q     <= cnt_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic dbl_rel, err_q;

    // rel_onehot is exactly SIZE wide, so only overlap with free entries can offend
    assign dbl_rel = rel_valid & (|(rel_onehot & free_mask));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (dbl_rel)
            err_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        assert (rst || !dbl_rel)
            else $error("free_list_mgr: release of already-free entry, mask=%h rel=%h",
                        free_mask, rel_onehot);
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mgr.sv
// Randomized bench for free_list_mgr against a per-entry behavioural free list.
module tb_free_list_mgr;

    localparam int SIZE = 8;
`ifdef FREE_LIST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       rel_valid = 1'b0;
    logic [7:0] rel_onehot = '0;
    logic       flush = 1'b0;
    logic       alloc_ready, full, empty, err;
    logic [7:0] alloc_onehot;
    logic [2:0] alloc_idx;
    logic [3:0] free_cnt;

    int checks = 0;
    int failures = 0;

    free_list_mgr #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_onehot (alloc_onehot),
        .alloc_idx    (alloc_idx),
        .rel_valid    (rel_valid),
        .rel_onehot   (rel_onehot),
        .flush        (flush),
        .free_cnt     (free_cnt),
        .full         (full),
        .empty        (empty),
        .err          (err)
    );

    always #5 clk = ~clk;

    // model: one flag per entry, 1 = free
    bit  m_free [SIZE];
    bit  m_err   = 1'b0;
    bit  m_valid = 1'b0;

    function automatic int m_lowest();
        for (int i = 0; i < SIZE; i++)
            if (m_free[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < SIZE; i++) c += int'(m_free[i]);
        return c;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m = '0;
        for (int i = 0; i < SIZE; i++) m[i] = m_free[i];
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int lo;
        if (rst) begin
            for (int i = 0; i < SIZE; i++) m_free[i] = 1'b1;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < SIZE; i++)
                if (rel_valid && rel_onehot[i] && m_free[i]) m_err = CHK;
            if (flush) begin
                for (int i = 0; i < SIZE; i++) m_free[i] = 1'b1;
            end else begin
                lo = m_lowest();
                if (alloc_req && lo >= 0) m_free[lo] = 1'b0;
                if (rel_valid)
                    for (int i = 0; i < SIZE; i++)
                        if (rel_onehot[i]) m_free[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int lo, cnt;
        if (m_valid) begin
            lo  = m_lowest();
            cnt = m_count();
            chk("alloc_ready",  alloc_ready,  32'(lo >= 0));
            chk("alloc_onehot", alloc_onehot, (lo >= 0) ? (32'd1 << lo) : 32'd0);
            chk("alloc_idx",    alloc_idx,    (lo >= 0) ? 32'(lo) : 32'd0);
            chk("free_cnt",     free_cnt,     32'(cnt));
            chk("full",         full,         32'(cnt == SIZE));
            chk("empty",        empty,        32'(cnt == 0));
            chk("err",          err,          32'(m_err));
        end
    end

    // inputs set here are consumed at the next posedge; outputs already reflect the last one
    task automatic step(input bit a, input bit rv, input logic [7:0] ro,
                        input bit fl, input bit r);
        @(posedge clk); #1;
        alloc_req = a; rel_valid = rv; rel_onehot = ro; flush = fl; rst = r;
    endtask

    initial begin
        step(0, 0, 8'h00, 0, 0);
        chk("rst_cnt",    free_cnt,     32'd8);
        chk("rst_full",   full,         32'd1);
        chk("rst_empty",  empty,        32'd0);
        chk("rst_onehot", alloc_onehot, 32'h01);
        chk("rst_idx",    alloc_idx,    32'd0);
        chk("rst_err",    err,          32'd0);

        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'h00, 0, 0);
            chk("seq_idx", alloc_idx, 32'(i));
            chk("seq_cnt", free_cnt,  32'(8 - i));
        end
        step(1, 0, 8'h00, 0, 0);
        chk("drain_cnt",   free_cnt,     32'd0);
        chk("drain_empty", empty,        32'd1);
        chk("drain_ready", alloc_ready,  32'd0);
        step(0, 0, 8'h00, 0, 0);
        chk("ninth_onehot", alloc_onehot, 32'h00);
        chk("ninth_cnt",    free_cnt,     32'd0);

        step(0, 1, 8'b0010_0100, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rel2_cnt", free_cnt,  32'd2);
        chk("rel2_idx", alloc_idx, 32'd2);
        step(1, 0, 8'h00, 0, 0);
        chk("rel2_idx5", alloc_idx, 32'd5);
        step(0, 1, 8'h01, 0, 0);
        chk("pre_mix_cnt", free_cnt, 32'd0);
        step(1, 1, 8'h80, 0, 0);
        chk("mix_idx", alloc_idx, 32'd0);
        step(0, 0, 8'h00, 0, 0);
        chk("mix_onehot", alloc_onehot, 32'h80);
        chk("mix_cnt",    free_cnt,     32'd1);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        chk("pre_flush_empty", empty, 32'd1);
        step(0, 0, 8'h00, 0, 0);
        chk("flush_cnt",  free_cnt, 32'd8);
        chk("flush_full", full,     32'd1);

        step(0, 1, 8'h01, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("dbl_cnt", free_cnt, 32'd8);
        chk("dbl_err", err,      32'(CHK));
        step(1, 0, 8'h00, 0, 0);
        chk("dbl_err_sticky", err, 32'(CHK));

        for (int n = 0; n < 400; n++) begin
            logic [7:0] ro;
            ro = 8'($urandom);
            if ($urandom_range(0, 1) == 0) ro = ro & ~m_mask();
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, ro,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
        end
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
